// File: rtl/z80_exec_ld_a_ind_bcde.sv
// LD A,(BC) / LD A,(DE) sequencer: one memory-read machine cycle, then A and WZ writeback.
// Optional macro Z80_BUS_WAIT_EN enables wait-state (TW) insertion from wait_n.
module z80_exec_ld_a_ind_bcde (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  opcode,
  input  logic [15:0] bc,
  input  logic [15:0] de,
  input  logic        wait_n,
  input  logic [7:0]  mem_din,
  output logic [15:0] mem_addr,
  output logic        mreq_n,
  output logic        rd_n,
  output logic        busy,
  output logic        done,
  output logic        a_we,
  output logic [7:0]  a_wdata,
  output logic        wz_we,
  output logic [15:0] wz_wdata,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_TW   = 3'd3,
    S_T3   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic        legal_s;
  logic        accept_s;
  logic        strobe_next_s;
  logic [15:0] mem_addr_r;
  logic        mreq_n_r;
  logic        rd_n_r;
  logic        busy_r;
  logic        done_r;
  logic        a_we_r;
  logic [7:0]  a_wdata_r;
  logic        wz_we_r;
  logic [15:0] wz_wdata_r;
  logic        illegal_r;

`ifndef Z80_BUS_WAIT_EN
  logic unused_wait_s;
  assign unused_wait_s = wait_n;
`endif

  assign legal_s  = (opcode[7:5] == 3'b000) && (opcode[3:0] == 4'b1010);
  assign accept_s = (state_r == S_IDLE) && start && legal_s;

  // Next-state selection for the read machine cycle
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) state_next_s = S_T1;
        else          state_next_s = S_IDLE;
      end
      S_T1: state_next_s = S_T2;
      S_T2: begin
`ifdef Z80_BUS_WAIT_EN
        if (!wait_n) state_next_s = S_TW;
        else         state_next_s = S_T3;
`else
        state_next_s = S_T3;
`endif
      end
      S_TW: begin
`ifdef Z80_BUS_WAIT_EN
        if (wait_n) state_next_s = S_T3;
        else        state_next_s = S_TW;
`else
        state_next_s = S_T3;
`endif
      end
      S_T3:    state_next_s = S_DONE;
      S_DONE:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  assign strobe_next_s = (state_next_s == S_T2) || (state_next_s == S_TW) ||
                         (state_next_s == S_T3);

  // State register and registered outputs, decoded one cycle ahead from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= S_IDLE;
      mem_addr_r <= 16'h0000;
      mreq_n_r   <= 1'b1;
      rd_n_r     <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      a_we_r     <= 1'b0;
      a_wdata_r  <= 8'h00;
      wz_we_r    <= 1'b0;
      wz_wdata_r <= 16'h0000;
      illegal_r  <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      mreq_n_r  <= !strobe_next_s;
      rd_n_r    <= !strobe_next_s;
      busy_r    <= (state_next_s != S_IDLE);
      done_r    <= (state_next_s == S_DONE);
      a_we_r    <= (state_next_s == S_DONE);
      wz_we_r   <= (state_next_s == S_DONE);
      illegal_r <= (state_r == S_IDLE) && start && !legal_s;
      if (accept_s) begin
        mem_addr_r <= opcode[4] ? de : bc;
      end
      // Read data is taken only on the edge leaving T3
      if (state_r == S_T3) begin
        a_wdata_r  <= mem_din;
        wz_wdata_r <= mem_addr_r + 16'd1;
      end
    end
  end

  assign mem_addr = mem_addr_r;
  assign mreq_n   = mreq_n_r;
  assign rd_n     = rd_n_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign a_we     = a_we_r;
  assign a_wdata  = a_wdata_r;
  assign wz_we    = wz_we_r;
  assign wz_wdata = wz_wdata_r;
  assign illegal  = illegal_r;

endmodule

// File: tb/tb_z80_exec_ld_a_ind_bcde.sv
// Directed bench for z80_exec_ld_a_ind_bcde; wait-state expectations follow Z80_BUS_WAIT_EN.
module tb_z80_exec_ld_a_ind_bcde;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  opcode;
  logic [15:0] bc;
  logic [15:0] de;
  logic        wait_n;
  logic [7:0]  mem_din;
  logic [15:0] mem_addr;
  logic        mreq_n;
  logic        rd_n;
  logic        busy;
  logic        done;
  logic        a_we;
  logic [7:0]  a_wdata;
  logic        wz_we;
  logic [15:0] wz_wdata;
  logic        illegal;

  int checks;
  int errors;

  z80_exec_ld_a_ind_bcde dut (
    .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode),
    .bc(bc), .de(de), .wait_n(wait_n), .mem_din(mem_din),
    .mem_addr(mem_addr), .mreq_n(mreq_n), .rd_n(rd_n), .busy(busy),
    .done(done), .a_we(a_we), .a_wdata(a_wdata), .wz_we(wz_we),
    .wz_wdata(wz_wdata), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // bus idle, not busy, no pulses
  task automatic chk_idle(input string tag);
    chk({tag, ".mreq_n"}, {31'd0, mreq_n}, 32'd1);
    chk({tag, ".rd_n"}, {31'd0, rd_n}, 32'd1);
    chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
    chk({tag, ".done"}, {31'd0, done}, 32'd0);
    chk({tag, ".a_we"}, {31'd0, a_we}, 32'd0);
  endtask

  // bus cycle status: mreq_n/rd_n expected value, busy=1, no done
  task automatic chk_bus(input string tag, input logic [15:0] addr, input logic strobe_n);
    chk({tag, ".addr"}, {16'd0, mem_addr}, {16'd0, addr});
    chk({tag, ".mreq_n"}, {31'd0, mreq_n}, {31'd0, strobe_n});
    chk({tag, ".rd_n"}, {31'd0, rd_n}, {31'd0, strobe_n});
    chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
    chk({tag, ".done"}, {31'd0, done}, 32'd0);
  endtask

  task automatic chk_done(input string tag, input logic [15:0] addr, input logic [7:0] data,
                          input logic [15:0] wz);
    chk({tag, ".addr"}, {16'd0, mem_addr}, {16'd0, addr});
    chk({tag, ".done"}, {31'd0, done}, 32'd1);
    chk({tag, ".a_we"}, {31'd0, a_we}, 32'd1);
    chk({tag, ".wz_we"}, {31'd0, wz_we}, 32'd1);
    chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
    chk({tag, ".mreq_n"}, {31'd0, mreq_n}, 32'd1);
    chk({tag, ".a_wdata"}, {24'd0, a_wdata}, {24'd0, data});
    chk({tag, ".wz_wdata"}, {16'd0, wz_wdata}, {16'd0, wz});
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    start   = 1'b0;
    opcode  = 8'h00;
    bc      = 16'h0000;
    de      = 16'h0000;
    wait_n  = 1'b1;
    mem_din = 8'h00;
    cyc();
    cyc();
    chk_idle("rst");
    chk("rst.addr", {16'd0, mem_addr}, 32'h0);
    chk("rst.a_wdata", {24'd0, a_wdata}, 32'h0);
    chk("rst.wz_wdata", {16'd0, wz_wdata}, 32'h0);
    chk("rst.illegal", {31'd0, illegal}, 32'd0);
    reset_n = 1'b1;
    cyc();

    // LD A,(BC), no waits
    start = 1'b1; opcode = 8'h0A; bc = 16'h1234; de = 16'h9999; mem_din = 8'h5A;
    cyc();
    start = 1'b0; bc = 16'hAAAA;
    chk_bus("bc.t1", 16'h1234, 1'b1);
    cyc();
    chk_bus("bc.t2", 16'h1234, 1'b0);
    cyc();
    chk_bus("bc.t3", 16'h1234, 1'b0);
    cyc();
    chk_done("bc.done", 16'h1234, 8'h5A, 16'h1235);
    cyc();
    chk_idle("bc.after");
    chk("bc.hold_a", {24'd0, a_wdata}, 32'h5A);
    chk("bc.hold_addr", {16'd0, mem_addr}, 32'h1234);

    // back-to-back LD A,(DE) with wrap, accepted at edge 5
    start = 1'b1; opcode = 8'h1A; de = 16'hFFFF; bc = 16'h0000; mem_din = 8'hC3;
    cyc();
    start = 1'b0; de = 16'h0000;
    chk_bus("de.t1", 16'hFFFF, 1'b1);
    cyc();
    chk_bus("de.t2", 16'hFFFF, 1'b0);
    cyc();
    chk_bus("de.t3", 16'hFFFF, 1'b0);
    cyc();
    chk_done("de.done", 16'hFFFF, 8'hC3, 16'h0000);
    cyc();
    chk_idle("de.after");

    // wait_n low in T2 and first TW
    start = 1'b1; opcode = 8'h0A; bc = 16'h0100; mem_din = 8'h11;
    cyc();
    start = 1'b0;
    chk_bus("w.t1", 16'h0100, 1'b1);
    cyc();
    chk_bus("w.t2", 16'h0100, 1'b0);
    wait_n = 1'b0; mem_din = 8'h22;
`ifdef Z80_BUS_WAIT_EN
    cyc();
    chk_bus("w.tw1", 16'h0100, 1'b0);
    mem_din = 8'h33;
    cyc();
    chk_bus("w.tw2", 16'h0100, 1'b0);
    wait_n = 1'b1; mem_din = 8'h44;
    cyc();
    chk_bus("w.t3", 16'h0100, 1'b0);
    chk("w.t3_a_hold", {24'd0, a_wdata}, 32'hC3);
    mem_din = 8'h77;
    cyc();
    chk_done("w.done6", 16'h0100, 8'h77, 16'h0101);
`else
    cyc();
    chk_bus("w.t3", 16'h0100, 1'b0);
    mem_din = 8'h77;
    cyc();
    wait_n = 1'b1;
    chk_done("w.done4", 16'h0100, 8'h77, 16'h0101);
`endif
    cyc();
    chk_idle("w.after");

    // illegal opcodes
    start = 1'b1; opcode = 8'h02;
    cyc();
    start = 1'b0;
    chk("ill02.pulse", {31'd0, illegal}, 32'd1);
    chk_idle("ill02");
    cyc();
    chk("ill02.clear", {31'd0, illegal}, 32'd0);
    chk_idle("ill02.next");
    start = 1'b1; opcode = 8'h2A;
    cyc();
    start = 1'b0;
    chk("ill2a.pulse", {31'd0, illegal}, 32'd1);
    chk_idle("ill2a");
    cyc();
    chk("ill2a.clear", {31'd0, illegal}, 32'd0);
    chk_idle("ill2a.next");

    // start during T2 is ignored
    start = 1'b1; opcode = 8'h0A; bc = 16'h4000; de = 16'h5555; mem_din = 8'h99;
    cyc();
    start = 1'b0;
    cyc();
    start = 1'b1; opcode = 8'h1A;
    cyc();
    start = 1'b0;
    chk_bus("ign.t3", 16'h4000, 1'b0);
    chk("ign.no_illegal", {31'd0, illegal}, 32'd0);
    cyc();
    chk_done("ign.done", 16'h4000, 8'h99, 16'h4001);
    cyc();
    chk_idle("ign.after");

    // reset dropped in T3
    start = 1'b1; opcode = 8'h0A; bc = 16'h2000; mem_din = 8'h66;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    chk_bus("rst3.t3", 16'h2000, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_idle("rst3.async");
    chk("rst3.addr", {16'd0, mem_addr}, 32'h0);
    chk("rst3.a_wdata", {24'd0, a_wdata}, 32'h0);
    chk("rst3.wz_wdata", {16'd0, wz_wdata}, 32'h0);
    cyc();
    chk("rst3.no_a_we", {31'd0, a_we}, 32'd0);
    chk("rst3.no_wz_we", {31'd0, wz_we}, 32'd0);
    reset_n = 1'b1;
    cyc();
    chk_idle("rst3.release");

    // fresh transfer after reset
    start = 1'b1; opcode = 8'h1A; de = 16'h0ABC; bc = 16'h1111; mem_din = 8'hE7;
    cyc();
    start = 1'b0;
    chk_bus("fr.t1", 16'h0ABC, 1'b1);
    cyc();
    chk_bus("fr.t2", 16'h0ABC, 1'b0);
    cyc();
    chk_bus("fr.t3", 16'h0ABC, 1'b0);
    cyc();
    chk_done("fr.done", 16'h0ABC, 8'hE7, 16'h0ABD);
    cyc();
    chk_idle("fr.after");
    chk("fr.hold_wz", {16'd0, wz_wdata}, 32'h0ABD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
